afpm_operand_deserializer: RTL
==============================

Name: afpm_operand_deserializer

Overview:
Upstream input stage for the logarithmic approximate FP16 multiplier. Assembles two 16-bit half-precision operands, A and B, from byte-serial streams, low byte first. A arrives on the dedicated-input byte and B on the bidirectional-input byte. Each assembled pair is classified and buffered in a small FIFO, then handed to the multiplier core over a valid/ready handshake.

Parameters:
DEPTH, 2, number of operand-pair entries in the output FIFO (power of two, >=2)
FLUSH_SUBNORMAL, 1, when 1 an operand with exponent field 0 is classified ZERO; when 0 it is classified NORMAL

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  byte strobe; in_a/in_b are sampled on a rising clk while high
in_sync  input  1  frame resync; forces the current byte to be treated as the low byte
in_a  input  8  operand A byte
in_b  input  8  operand B byte
out_valid  output  1  FIFO non-empty; head entry is presented
out_ready  input  1  consumer accepts head entry
op_a  output  16  head operand A
op_b  output  16  head operand B
cls_a  output  2  class of op_a: 00 NORMAL, 01 ZERO, 10 INF, 11 NAN
cls_b  output  2  class of op_b, same encoding
level  output  $clog2(DEPTH)+1  current FIFO occupancy
overrun  output  1  sticky: a completed pair was dropped because the FIFO was full
ovr_clr  input  1  clears overrun

Behaviour:
- Reset (async assert, sync release): byte state = LOW; lo_a/lo_b = 0; FIFO empty; out_valid=0; op_a/op_b=0; cls_a/cls_b=00; level=0; overrun=0.
- Byte FSM states: LOW (expecting low byte) and HIGH (expecting high byte). Events are evaluated on rising clk:
  - LOW & in_valid: capture lo_a=in_a, lo_b=in_b; go to HIGH.
  - HIGH & in_valid & !in_sync: form A={in_a,lo_a}, B={in_b,lo_b}; attempt a push; go to LOW.
  - in_sync & in_valid, any state: treat as a low-byte capture; go to HIGH. Any partial pair is discarded.
  - in_sync & !in_valid: go to LOW; partial pair is discarded.
  - !in_valid: hold state.
- Classification is computed combinationally on the assembled word and stored with the entry:
  - exp=0x1F & mant!=0 -> NAN
  - exp=0x1F & mant=0 -> INF
  - exp=0 -> ZERO if FLUSH_SUBNORMAL, otherwise NORMAL
  - otherwise NORMAL
  - The sign bit is ignored for class.
- FIFO: circular buffer, DEPTH entries of {A,B,cls_a,cls_b}, with read/write pointers wrapping modulo DEPTH.
  - Pop = out_valid & out_ready.
  - Push succeeds if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - A push that fails drops the pair and sets overrun=1.
  - Simultaneous push and pop leaves level unchanged.
  - Pop on empty is impossible because out_valid=0.
- Outputs op_a/op_b/cls_a/cls_b always reflect the head entry. They are registered and stable while out_valid=1 & out_ready=0.
- Latency: the high byte sampled at edge N with the FIFO empty gives out_valid=1 after edge N (visible cycle N+1). Throughput is one pair per two in_valid strobes.
- The producer may hold a byte for multiple cycles; only in_valid pulses count. Holding in_valid high for k cycles consumes k bytes.
- overrun: set on a dropped pair; cleared by ovr_clr. If set and clear occur in the same cycle, set wins.
- rst asserted mid-frame or mid-FIFO: everything returns to reset values immediately; no partial output.

Test Plan:
1. in_valid pulses with (a,b) = (00,00) then (3E,42), out_ready=1 -> one cycle after the second strobe: out_valid=1, op_a=3E00, op_b=4200, cls_a=cls_b=00; level returns to 0 after the pop.
2. Pairs A=0000/B=8000, A=7C00/B=FC00, A=7E00/B=7C01 -> classes (01,01), (10,10), (11,11). A=0001 gives 01 when FLUSH_SUBNORMAL=1 and 00 when it is 0.
3. out_ready=0, three pairs (1111/2222, 3333/4444, 5555/6666), DEPTH=2 -> level=2, overrun=1, head holds 1111/2222; then out_ready=1 -> 1111/2222 then 3333/4444 in order, 5555 never appears.
4. Full FIFO, out_ready=1 in the same cycle the high byte of a third pair arrives -> push accepted, level stays 2, overrun stays 0.
5. Low byte (AA,BB) strobed, then in_sync+in_valid with (00,00), then (3E,42) -> output 3E00/4200; AA/BB discarded. in_sync alone after a low byte -> no output, FSM in LOW.
6. rst pulsed between the low and high bytes, and separately with level=2 -> out_valid=0, level=0, overrun=0 immediately. The next full pair (00,00),(40,40) outputs 4000/4000.

Source files
------------

// File: rtl/afpm_operand_deserializer_if.sv
// Operand-stream bundle between the byte producer, the deserializer and the multiplier core.
interface afpm_operand_deserializer_if #(
    parameter int unsigned DEPTH = 2
);
    logic                     in_valid;
    logic                     in_sync;
    logic [7:0]               in_a;
    logic [7:0]               in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [15:0]              op_a;
    logic [15:0]              op_b;
    logic [1:0]               cls_a;
    logic [1:0]               cls_b;
    logic [$clog2(DEPTH):0]   level;
    logic                     overrun;
    logic                     ovr_clr;

    modport master (
        output in_valid, in_sync, in_a, in_b, out_ready, ovr_clr,
        input  out_valid, op_a, op_b, cls_a, cls_b, level, overrun
    );

    modport slave (
        input  in_valid, in_sync, in_a, in_b, out_ready, ovr_clr,
        output out_valid, op_a, op_b, cls_a, cls_b, level, overrun
    );
endinterface

// File: rtl/afpm_operand_deserializer.sv
// Byte-serial FP16 operand pair assembler with per-operand classification and an output FIFO.
module afpm_operand_deserializer #(
    parameter int unsigned DEPTH           = 2,
    parameter bit          FLUSH_SUBNORMAL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    afpm_operand_deserializer_if.slave    bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    typedef enum logic {LOW, HIGH} state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  ca;
        logic [1:0]  cb;
    } entry_t;

    function automatic logic [1:0] classify(input logic [15:0] w);
        if (w[14:10] == 5'h1F) return (w[9:0] != 10'd0) ? 2'b11 : 2'b10;
        if (w[14:10] == 5'h00) return FLUSH_SUBNORMAL ? 2'b01 : 2'b00;
        return 2'b00;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        lo_a_q, lo_a_d, lo_b_q, lo_b_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              overrun_q, overrun_d;
    entry_t            mem_q [DEPTH];
    entry_t            new_entry, head;
    logic              push_req, push_ok, pop;

    always_comb begin
        state_d   = state_q;
        lo_a_d    = lo_a_q;
        lo_b_d    = lo_b_q;
        push_req  = bus.in_valid && !bus.in_sync && (state_q == HIGH);
        pop       = (level_q != '0) && bus.out_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push_ok   = push_req && ((level_q != LW'(DEPTH)) || pop);

        new_entry.a  = {bus.in_a, lo_a_q};
        new_entry.b  = {bus.in_b, lo_b_q};
        new_entry.ca = classify(new_entry.a);
        new_entry.cb = classify(new_entry.b);

        if (bus.in_valid) begin
            if (bus.in_sync || state_q == LOW) begin
                lo_a_d  = bus.in_a;
                lo_b_d  = bus.in_b;
                state_d = HIGH;
            end else begin
                state_d = LOW;
            end
        end else if (bus.in_sync) begin
            state_d = LOW;
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (push_req && !push_ok) overrun_d = 1'b1;
        else if (bus.ovr_clr)     overrun_d = 1'b0;
        else                      overrun_d = overrun_q;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOW;
            lo_a_q    <= '0;
            lo_b_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            lo_a_q    <= lo_a_d;
            lo_b_q    <= lo_b_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.out_valid = (level_q != '0);
    assign bus.op_a      = head.a;
    assign bus.op_b      = head.b;
    assign bus.cls_a     = head.ca;
    assign bus.cls_b     = head.cb;
    assign bus.level     = level_q;
    assign bus.overrun   = overrun_q;
endmodule
